aib_lane_remap: RTL and testbench

- Parametrised successor to the fixed AIB channel I/O mapping. Logical Tx/Rx lanes reach physical AIB I/Os through run-time programmable lane→IO tables instead of hard-wired rotated/master presets.
- Tables are written into shadow registers. A commit handshake quiesces the datapath, checks the shadow tables for collisions and swaps them into the active tables without glitching.
- Sits between the channel adapter and aib_io_block.

---
 rtl/aib_lane_remap_pkg.sv | 24 ++
 rtl/aib_lane_remap_if.sv | 52 +++++
 rtl/aib_lane_remap_chk.sv | 69 ++++++
 rtl/aib_lane_remap.sv | 194 +++++++++++++++++++
 tb/tb_aib_lane_remap.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aib_lane_remap_pkg.sv
// Shared types and identity-map helpers for the AIB lane remapper.
package aib_lane_remap_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      QUIESCE,
      SWAP,
      RESUME
   } state_e;

   // Wide enough for any supported IO count; narrow with IdxW'(...) at use.
   localparam int unsigned MaxIdxW = 16;
   typedef logic [MaxIdxW-1:0] lane_idx_t;

   function automatic lane_idx_t ident_tx(input int unsigned lane);
      return lane_idx_t'(lane);
   endfunction

   function automatic lane_idx_t ident_rx(input int unsigned lane, input int unsigned num_lanes);
      return lane_idx_t'(lane + num_lanes);
   endfunction

endpackage

// File: rtl/aib_lane_remap_if.sv
// Control and datapath bundle between channel adapter, remapper and aib_io_block.
// c_loopback exists only when AIB_LANE_REMAP_LOOPBACK_EN is defined.
interface aib_lane_remap_if #(
   parameter int unsigned NumIo    = 96,
   parameter int unsigned NumLanes = 20,
   parameter int unsigned IdxW     = $clog2(NumIo),
   parameter int unsigned LaneW    = $clog2(NumLanes)
);
   logic                c_wr_en;
   logic                c_wr_dir;
   logic [LaneW-1:0]    c_wr_lane;
   logic [IdxW-1:0]     c_wr_idx;
   logic                c_commit;
   logic                o_busy;
   logic                o_commit_done;
   logic                o_commit_err;
   logic [NumLanes-1:0] i_tx_data0;
   logic [NumLanes-1:0] i_tx_data1;
   logic [NumIo-1:0]    o_iob_tx_en;
   logic [NumIo-1:0]    o_iob_tx_data0;
   logic [NumIo-1:0]    o_iob_tx_data1;
   logic [NumIo-1:0]    i_iob_rx_data0;
   logic [NumIo-1:0]    i_iob_rx_data1;
   logic [NumLanes-1:0] o_rx_data0;
   logic [NumLanes-1:0] o_rx_data1;
   logic                o_rx_valid;
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
   logic                c_loopback;
`endif

   modport slave (
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      input  c_loopback,
`endif
      input  c_wr_en, c_wr_dir, c_wr_lane, c_wr_idx, c_commit,
      input  i_tx_data0, i_tx_data1, i_iob_rx_data0, i_iob_rx_data1,
      output o_busy, o_commit_done, o_commit_err,
      output o_iob_tx_en, o_iob_tx_data0, o_iob_tx_data1,
      output o_rx_data0, o_rx_data1, o_rx_valid
   );

   modport master (
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      output c_loopback,
`endif
      output c_wr_en, c_wr_dir, c_wr_lane, c_wr_idx, c_commit,
      output i_tx_data0, i_tx_data1, i_iob_rx_data0, i_iob_rx_data1,
      input  o_busy, o_commit_done, o_commit_err,
      input  o_iob_tx_en, o_iob_tx_data0, o_iob_tx_data1,
      input  o_rx_data0, o_rx_data1, o_rx_valid
   );
endinterface

// File: rtl/aib_lane_remap_chk.sv
// Sequential collision checker: walks Tx then Rx shadow entries, one per cycle,
// flagging out-of-range indices, duplicates within a direction and Tx/Rx overlap.
module aib_lane_remap_chk
   import aib_lane_remap_pkg::*;
#(
   parameter int unsigned NumIo    = 96,
   parameter int unsigned NumLanes = 20,
   parameter int unsigned IdxW     = $clog2(NumIo)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [NumLanes-1:0][IdxW-1:0] tx_tab_i,
   input  logic [NumLanes-1:0][IdxW-1:0] rx_tab_i,
   output logic                          last_c_o,
   output logic                          err_c_o
);
   localparam int unsigned Entries = 2 * NumLanes;
   localparam int unsigned CntW    = $clog2(Entries);
   localparam int unsigned LaneW   = $clog2(NumLanes);

   logic             active_q;
   logic [CntW-1:0]  cnt_q;
   logic [NumIo-1:0] occ_tx_q, occ_rx_q;
   logic             err_q;

   logic             is_rx_c, in_range_c, hit_c, fail_c;
   logic [LaneW-1:0] lane_c;
   logic [IdxW-1:0]  idx_c;

   // Current entry lookup; the Rx pass also tests against the full Tx occupancy.
   always_comb begin
      is_rx_c    = cnt_q >= CntW'(NumLanes);
      lane_c     = is_rx_c ? LaneW'(cnt_q - CntW'(NumLanes)) : LaneW'(cnt_q);
      idx_c      = is_rx_c ? rx_tab_i[lane_c] : tx_tab_i[lane_c];
      in_range_c = 32'(idx_c) < NumIo;
      hit_c      = 1'b0;
      if (in_range_c) begin
         hit_c = occ_tx_q[idx_c] | (is_rx_c & occ_rx_q[idx_c]);
      end
      fail_c   = active_q & (~in_range_c | hit_c);
      last_c_o = active_q & (cnt_q == CntW'(Entries - 1));
      err_c_o  = err_q | fail_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         occ_tx_q <= '0;
         occ_rx_q <= '0;
         err_q    <= 1'b0;
      end else if (start_i) begin
         active_q <= 1'b1;
         cnt_q    <= '0;
         occ_tx_q <= '0;
         occ_rx_q <= '0;
         err_q    <= 1'b0;
      end else if (active_q) begin
         cnt_q <= cnt_q + CntW'(1);
         err_q <= err_c_o;
         if (in_range_c) begin
            if (is_rx_c) occ_rx_q[idx_c] <= 1'b1;
            else         occ_tx_q[idx_c] <= 1'b1;
         end
         if (last_c_o) active_q <= 1'b0;
      end
   end
endmodule

// File: rtl/aib_lane_remap.sv
// Run-time programmable lane->IO remapper with glitch-free shadow/active table commit.
// Optional loopback (c_loopback) is built when AIB_LANE_REMAP_LOOPBACK_EN is defined.
module aib_lane_remap
   import aib_lane_remap_pkg::*;
#(
   parameter int unsigned NumIo       = 96,
   parameter int unsigned NumLanes    = 20,
   parameter int unsigned IdxW        = $clog2(NumIo),
   parameter int unsigned DrainCycles = 4
) (
   input logic             i_clk,
   input logic             i_rstn,
   aib_lane_remap_if.slave bus
);
   localparam int unsigned DrainW = $clog2(DrainCycles + 1);
   typedef logic [NumLanes-1:0][IdxW-1:0] map_t;

   state_e              state_q, state_d;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic                busy_q, done_q, done_d, err_q, err_d;
   logic                chk_start_c, chk_last_c, chk_err_c, swap_c, wr_ok_c, drain_last_c;
   map_t                shadow_tx_q, shadow_rx_q, active_tx_q, active_rx_q;
   logic                quiet_c, rx_valid_c, rx_valid_q;
   logic [NumIo-1:0]    tx_en_c, tx_d0_c, tx_d1_c, tx_en_q, tx_d0_q, tx_d1_q;
   logic [NumLanes-1:0] rx0_c, rx1_c, rx0_q, rx1_q;

   aib_lane_remap_chk #(.NumIo(NumIo), .NumLanes(NumLanes), .IdxW(IdxW)) u_chk (
      .clk      (i_clk),
      .rst_n    (i_rstn),
      .start_i  (chk_start_c),
      .tx_tab_i (shadow_tx_q),
      .rx_tab_i (shadow_rx_q),
      .last_c_o (chk_last_c),
      .err_c_o  (chk_err_c)
   );

   assign wr_ok_c      = (state_q == IDLE) && bus.c_wr_en && (32'(bus.c_wr_lane) < NumLanes);
   assign drain_last_c = drain_q == DrainW'(DrainCycles - 1);

   // Commit sequencer: CHECK -> QUIESCE -> SWAP -> RESUME, or back to IDLE on a bad table.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      err_d       = err_q;
      done_d      = 1'b0;
      chk_start_c = 1'b0;
      swap_c      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.c_commit) begin
               chk_start_c = 1'b1;
               err_d       = 1'b0;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (chk_last_c) begin
               drain_d = '0;
               if (chk_err_c) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = QUIESCE;
               end
            end
         end
         QUIESCE: begin
            drain_d = drain_q + DrainW'(1);
            if (drain_last_c) begin
               drain_d = '0;
               state_d = SWAP;
            end
         end
         SWAP: begin
            swap_c  = 1'b1;
            drain_d = '0;
            state_d = RESUME;
         end
         RESUME: begin
            drain_d = drain_q + DrainW'(1);
            if (drain_last_c) begin
               drain_d = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         busy_q  <= state_d != IDLE;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int unsigned l = 0; l < NumLanes; l++) begin
            shadow_tx_q[l] <= IdxW'(ident_tx(l));
            shadow_rx_q[l] <= IdxW'(ident_rx(l, NumLanes));
            active_tx_q[l] <= IdxW'(ident_tx(l));
            active_rx_q[l] <= IdxW'(ident_rx(l, NumLanes));
         end
      end else begin
         if (wr_ok_c) begin
            if (bus.c_wr_dir) shadow_rx_q[bus.c_wr_lane] <= bus.c_wr_idx;
            else              shadow_tx_q[bus.c_wr_lane] <= bus.c_wr_idx;
         end
         if (swap_c) begin
            active_tx_q <= shadow_tx_q;
            active_rx_q <= shadow_rx_q;
         end
      end
   end

`ifdef AIB_LANE_REMAP_LOOPBACK_EN
   logic lb_q;
   // Loopback mode only changes while no commit is in flight.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)               lb_q <= 1'b0;
      else if (state_q == IDLE)  lb_q <= bus.c_loopback;
   end
`endif

   always_comb begin
      tx_en_c = '0;
      tx_d0_c = '0;
      tx_d1_c = '0;
      rx0_c   = '0;
      rx1_c   = '0;
      quiet_c = state_q inside {QUIESCE, SWAP, RESUME};
      for (int unsigned l = 0; l < NumLanes; l++) begin
         if (32'(active_tx_q[l]) < NumIo) begin
            tx_en_c[active_tx_q[l]] = 1'b1;
            tx_d0_c[active_tx_q[l]] = bus.i_tx_data0[l] & ~quiet_c;
            tx_d1_c[active_tx_q[l]] = bus.i_tx_data1[l] & ~quiet_c;
         end
         if (32'(active_rx_q[l]) < NumIo) begin
            rx0_c[l] = bus.i_iob_rx_data0[active_rx_q[l]];
            rx1_c[l] = bus.i_iob_rx_data1[active_rx_q[l]];
         end
      end
      rx_valid_c = ~quiet_c;
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      if (lb_q) begin
         tx_en_c    = '0;
         tx_d0_c    = '0;
         tx_d1_c    = '0;
         rx0_c      = bus.i_tx_data0;
         rx1_c      = bus.i_tx_data1;
         rx_valid_c = 1'b1;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         tx_en_q    <= '0;
         tx_d0_q    <= '0;
         tx_d1_q    <= '0;
         rx0_q      <= '0;
         rx1_q      <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         tx_en_q    <= tx_en_c;
         tx_d0_q    <= tx_d0_c;
         tx_d1_q    <= tx_d1_c;
         rx0_q      <= rx0_c;
         rx1_q      <= rx1_c;
         rx_valid_q <= rx_valid_c;
      end
   end

   assign bus.o_busy         = busy_q;
   assign bus.o_commit_done  = done_q;
   assign bus.o_commit_err   = err_q;
   assign bus.o_iob_tx_en    = tx_en_q;
   assign bus.o_iob_tx_data0 = tx_d0_q;
   assign bus.o_iob_tx_data1 = tx_d1_q;
   assign bus.o_rx_data0     = rx0_q;
   assign bus.o_rx_data1     = rx1_q;
   assign bus.o_rx_valid     = rx_valid_q;
endmodule

// File: tb/tb_aib_lane_remap.sv
// Scoreboard bench for aib_lane_remap: a cycle model predicts every output each edge.
module tb_aib_lane_remap;
   localparam int NumIo    = 96;
   localparam int NumLanes = 20;
   localparam int Drain    = 4;
   localparam int ChkLen   = 2 * NumLanes;
   localparam int SwapEdge = ChkLen + Drain + 1;
   localparam int EndEdge  = ChkLen + 2 * Drain + 1;

   typedef struct packed {
      logic             busy;
      logic             done;
      logic             err;
      logic             rxv;
      logic [NumIo-1:0] en;
      logic [NumIo-1:0] d0;
      logic [NumIo-1:0] d1;
      logic [19:0]      r0;
      logic [19:0]      r1;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aib_lane_remap_if #(.NumIo(NumIo), .NumLanes(NumLanes)) bus ();
   aib_lane_remap #(.NumIo(NumIo), .NumLanes(NumLanes), .DrainCycles(Drain)) dut (
      .i_clk  (clk),
      .i_rstn (rst_n),
      .bus    (bus)
   );

   exp_t exp_q[$];
   int   m_tx[NumLanes], m_rx[NumLanes], m_atx[NumLanes], m_arx[NumLanes];
   int   m_seq;
   bit   m_fail, m_err, m_lb, lb_in;
   int   n_checks = 0, n_errors = 0;
   int   busy_cnt, done_cnt;
   bit   tx0_fix_en;
   logic [19:0] tx0_fix;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int l = 0; l < NumLanes; l++) begin
         m_tx[l] = l; m_rx[l] = NumLanes + l;
         m_atx[l] = l; m_arx[l] = NumLanes + l;
      end
      m_seq = -1; m_fail = 0; m_err = 0; m_lb = 0;
   endtask

   // Any out-of-range index or any repeated index across all 40 entries is a collision.
   function automatic bit shadow_bad();
      int all[2*NumLanes];
      for (int i = 0; i < NumLanes; i++) begin
         all[i] = m_tx[i];
         all[NumLanes+i] = m_rx[i];
      end
      for (int i = 0; i < 2 * NumLanes; i++) begin
         if (all[i] >= NumIo) return 1'b1;
         for (int j = 0; j < i; j++) if (all[j] == all[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // 0 idle, 1 check, 2 quiesce, 3 swap, 4 resume
   function automatic int phase(input int seq);
      if (seq < 0) return 0;
      if (seq < ChkLen) return 1;
      if (seq < ChkLen + Drain) return 2;
      if (seq == ChkLen + Drain) return 3;
      return 4;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 128'(bus.o_busy), 128'(0));
      check({tag, "_done"}, 128'(bus.o_commit_done), 128'(0));
      check({tag, "_err"}, 128'(bus.o_commit_err), 128'(0));
      check({tag, "_rxv"}, 128'(bus.o_rx_valid), 128'(0));
      check({tag, "_en"}, 128'(bus.o_iob_tx_en), 128'(0));
      check({tag, "_d0"}, 128'(bus.o_iob_tx_data0), 128'(0));
      check({tag, "_d1"}, 128'(bus.o_iob_tx_data1), 128'(0));
      check({tag, "_r0"}, 128'(bus.o_rx_data0), 128'(0));
      check({tag, "_r1"}, 128'(bus.o_rx_data1), 128'(0));
   endtask

   task automatic step(input bit wr_en, input bit dir, input int lane, input int idx, input bit commit);
      exp_t e;
      int   ph;
      bit   quiet;
      bus.c_wr_en = wr_en; bus.c_wr_dir = dir;
      bus.c_wr_lane = 5'(lane); bus.c_wr_idx = 7'(idx); bus.c_commit = commit;
      bus.i_tx_data0 = tx0_fix_en ? tx0_fix : 20'($urandom);
      bus.i_tx_data1 = 20'($urandom);
      bus.i_iob_rx_data0 = {$urandom, $urandom, $urandom};
      bus.i_iob_rx_data1 = {$urandom, $urandom, $urandom};
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      bus.c_loopback = lb_in;
`endif
      ph = phase(m_seq);
      quiet = ph >= 2;
      e = '0;
      for (int l = 0; l < NumLanes; l++) begin
         e.en[m_atx[l]] = 1'b1;
         if (!quiet) begin
            e.d0[m_atx[l]] = bus.i_tx_data0[l];
            e.d1[m_atx[l]] = bus.i_tx_data1[l];
         end
         e.r0[l] = bus.i_iob_rx_data0[m_arx[l]];
         e.r1[l] = bus.i_iob_rx_data1[m_arx[l]];
      end
      e.rxv = !quiet;
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      if (m_lb) begin
         e.en = '0; e.d0 = '0; e.d1 = '0;
         e.r0 = bus.i_tx_data0; e.r1 = bus.i_tx_data1; e.rxv = 1'b1;
      end
      if (ph == 0) m_lb = lb_in;
`endif
      if (ph == 0) begin
         if (wr_en && lane < NumLanes) begin
            if (dir) m_rx[lane] = idx;
            else     m_tx[lane] = idx;
         end
         if (commit) begin
            m_err = 0; m_fail = shadow_bad(); m_seq = 0;
         end
      end else begin
         m_seq++;
         if (m_fail && m_seq == ChkLen) begin
            m_err = 1; m_seq = -1;
         end else if (!m_fail && m_seq == SwapEdge) begin
            m_atx = m_tx; m_arx = m_rx;
         end else if (!m_fail && m_seq == EndEdge) begin
            e.done = 1'b1; m_seq = -1;
         end
      end
      e.busy = m_seq >= 0;
      e.err  = m_err;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check("busy", 128'(bus.o_busy), 128'(e.busy));
      check("done", 128'(bus.o_commit_done), 128'(e.done));
      check("err", 128'(bus.o_commit_err), 128'(e.err));
      check("rx_valid", 128'(bus.o_rx_valid), 128'(e.rxv));
      check("tx_en", 128'(bus.o_iob_tx_en), 128'(e.en));
      check("tx_d0", 128'(bus.o_iob_tx_data0), 128'(e.d0));
      check("tx_d1", 128'(bus.o_iob_tx_data1), 128'(e.d1));
      if (e.rxv) begin
         check("rx_d0", 128'(bus.o_rx_data0), 128'(e.r0));
         check("rx_d1", 128'(bus.o_rx_data1), 128'(e.r1));
      end
      busy_cnt += int'(bus.o_busy);
      done_cnt += int'(bus.o_commit_done);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic wr(input bit dir, input int lane, input int idx);
      step(1, dir, lane, idx, 0);
   endtask

   initial begin
      logic [NumIo-1:0] ident_en;
      ident_en = {76'b0, 20'hFFFFF};
      bus.c_wr_en = 0; bus.c_wr_dir = 0; bus.c_wr_lane = '0; bus.c_wr_idx = '0; bus.c_commit = 0;
      bus.i_tx_data0 = '0; bus.i_tx_data1 = '0; bus.i_iob_rx_data0 = '0; bus.i_iob_rx_data1 = '0;
      lb_in = 0; tx0_fix_en = 0; tx0_fix = '0;
`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      bus.c_loopback = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // identity map right after reset
      tx0_fix_en = 1; tx0_fix = 20'h00020;
      step(0, 0, 0, 0, 0);
      check("id_en", 128'(bus.o_iob_tx_en), 128'(ident_en));
      check("id_lane5", 128'(bus.o_iob_tx_data0[5]), 128'(1));
      check("id_rxv", 128'(bus.o_rx_valid), 128'(1));
      tx0_fix_en = 0;
      idle(3);

      // good remap; a write during busy and an out-of-range lane are ignored
      wr(0, 0, 52);
      wr(0, 1, 51);
      wr(0, 25, 0);
      busy_cnt = 0; done_cnt = 0;
      step(0, 0, 0, 0, 1);
      step(1, 0, 10, 90, 0);
      idle(55);
      check("t2_busy_cycles", 128'(busy_cnt), 128'(EndEdge));
      check("t2_done_pulses", 128'(done_cnt), 128'(1));
      tx0_fix_en = 1; tx0_fix = 20'h00001;
      step(0, 0, 0, 0, 0);
      check("t2_io52", 128'(bus.o_iob_tx_data0[52]), 128'(1));
      check("t2_en0", 128'(bus.o_iob_tx_en[0]), 128'(0));
      tx0_fix_en = 0;

      // duplicate Tx index
      wr(0, 3, 60);
      wr(0, 4, 60);
      busy_cnt = 0; done_cnt = 0;
      step(0, 0, 0, 0, 1);
      idle(45);
      check("t3_err", 128'(bus.o_commit_err), 128'(1));
      check("t3_busy_cycles", 128'(busy_cnt), 128'(ChkLen));
      check("t3_done_pulses", 128'(done_cnt), 128'(0));
      wr(0, 3, 3);
      wr(0, 4, 4);

      // Rx lane overlapping a Tx IO, then a good commit with a same-cycle write
      wr(1, 2, 7);
      step(0, 0, 0, 0, 1);
      idle(45);
      check("t4_err", 128'(bus.o_commit_err), 128'(1));
      done_cnt = 0;
      step(1, 1, 2, 22, 1);
      idle(55);
      check("t4_err_clr", 128'(bus.o_commit_err), 128'(0));
      check("t4_done_pulses", 128'(done_cnt), 128'(1));

      // index beyond the last IO
      wr(0, 8, 100);
      step(0, 0, 0, 0, 1);
      idle(45);
      check("t4b_err", 128'(bus.o_commit_err), 128'(1));
      wr(0, 8, 8);

      // reset during QUIESCE aborts the commit
      wr(0, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 60 && m_seq != ChkLen + 1; i++) step(0, 0, 0, 0, 0);
      check("t5_in_quiesce", 128'(phase(m_seq)), 128'(2));
      #1 rst_n = 1'b0;
      #1 check_zero("t5_rst");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("t5_hold");
      rst_n = 1'b1;
      done_cnt = 0;
      idle(60);
      check("t5_no_done", 128'(done_cnt), 128'(0));
      check("t5_id_en", 128'(bus.o_iob_tx_en), 128'(ident_en));

`ifdef AIB_LANE_REMAP_LOOPBACK_EN
      lb_in = 1;
      idle(3);
      tx0_fix_en = 1; tx0_fix = 20'hA5A5A;
      step(0, 0, 0, 0, 0);
      check("t6_lb_rx", 128'(bus.o_rx_data0), 128'(20'hA5A5A));
      check("t6_lb_en", 128'(bus.o_iob_tx_en), 128'(0));
      tx0_fix_en = 0;
      lb_in = 0;
      idle(4);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
